aes_axi4_burst_buffer: RTL and testbench



---
 rtl/aes_axi4_burst_buffer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_aes_axi4_burst_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_axi4_burst_buffer.sv
// AXI4-full slave word store staging ciphertext, key and IV blocks for the AES decrypt core.
// Supports INCR/WRAP/FIXED bursts, byte strobes, independent read/write channels and sticky SLVERR.
module aes_axi4_burst_buffer #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_DEPTH            = 16
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [2:0]                        S_AXI_AWSIZE,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [2:0]                        S_AXI_ARSIZE,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int IW       = C_S_AXI_ID_WIDTH;
  localparam int NB       = DW / 8;
  localparam int ADDR_LSB = $clog2(NB);
  localparam int IDX_W    = $clog2(C_DEPTH);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  function automatic logic beat_legal(input logic [AW-1:0] addr, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    beat_legal  = (size == 3'(ADDR_LSB)) && (burst != 2'b11) &&
                  !((burst == 2'b10) && !wrap_len_ok) &&
                  ((addr >> ADDR_LSB) < AW'(C_DEPTH));
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                               input logic [1:0] burst);
    logic [AW-1:0] mask;
    mask = AW'((32'(len) + 32'd1) * 32'(NB) - 32'd1);
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~mask) | ((addr + AW'(NB)) & mask);
      default: next_addr = addr + AW'(NB);
    endcase
  endfunction

  logic [DW-1:0] mem [C_DEPTH];

  w_state_e w_state_r, w_state_s;
  r_state_e r_state_r, r_state_s;

  logic          awready_r, wready_r, bvalid_r;
  logic [1:0]    bresp_r;
  logic [IW-1:0] bid_r, wid_r;
  logic [AW-1:0] waddr_r;
  logic [7:0]    wlen_r, wbeat_r;
  logic [2:0]    wsize_r;
  logic [1:0]    wburst_r;
  logic          werr_r;

  logic          arready_r, rvalid_r, rlast_r;
  logic [1:0]    rresp_r;
  logic [DW-1:0] rdata_r;
  logic [IW-1:0] rid_r;
  logic [AW-1:0] raddr_r;
  logic [7:0]    rlen_r, rbeat_r;
  logic [2:0]    rsize_r;
  logic [1:0]    rburst_r;

  logic          aw_hs_s, w_hs_s, w_last_beat_s, w_legal_s, w_beat_err_s;
  logic          ar_hs_s, r_hs_s, ar_legal_s, r_nxt_legal_s;
  logic [AW-1:0] r_nxt_addr_s;

  assign aw_hs_s       = S_AXI_AWVALID && awready_r;
  assign w_hs_s        = S_AXI_WVALID && wready_r;
  assign w_last_beat_s = (wbeat_r == wlen_r);
  assign w_legal_s     = beat_legal(waddr_r, wlen_r, wsize_r, wburst_r);
  assign w_beat_err_s  = !w_legal_s || (S_AXI_WLAST != w_last_beat_s);
  assign ar_hs_s       = S_AXI_ARVALID && arready_r;
  assign r_hs_s        = rvalid_r && S_AXI_RREADY;
  assign ar_legal_s    = beat_legal(S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST);
  assign r_nxt_addr_s  = next_addr(raddr_r, rlen_r, rburst_r);
  assign r_nxt_legal_s = beat_legal(r_nxt_addr_s, rlen_r, rsize_r, rburst_r);

  // State registers for both channel FSMs
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_r <= W_IDLE;
      r_state_r <= R_IDLE;
    end else begin
      w_state_r <= w_state_s;
      r_state_r <= r_state_s;
    end
  end

  // Write channel next state
  always_comb begin
    w_state_s = w_state_r;
    case (w_state_r)
      W_IDLE:  if (aw_hs_s) w_state_s = W_DATA; else w_state_s = W_IDLE;
      W_DATA:  if (w_hs_s && w_last_beat_s) w_state_s = W_RESP; else w_state_s = W_DATA;
      W_RESP:  if (S_AXI_BREADY) w_state_s = W_IDLE; else w_state_s = W_RESP;
      default: w_state_s = W_IDLE;
    endcase
  end

  // Read channel next state
  always_comb begin
    r_state_s = r_state_r;
    case (r_state_r)
      R_IDLE:  if (ar_hs_s) r_state_s = R_DATA; else r_state_s = R_IDLE;
      R_DATA:  if (r_hs_s && rlast_r) r_state_s = R_IDLE; else r_state_s = R_DATA;
      default: r_state_s = R_IDLE;
    endcase
  end

  // Byte-lane store; storage deliberately survives reset
  always_ff @(posedge ACLK) begin
    if (!ARESET && (w_state_r == W_DATA) && w_hs_s && w_legal_s) begin
      for (int b = 0; b < NB; b++) begin
        if (S_AXI_WSTRB[b]) mem[waddr_r[ADDR_LSB +: IDX_W]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Write channel burst tracking and response
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awready_r <= 1'b1;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
      bid_r     <= '0;
      wid_r     <= '0;
      waddr_r   <= '0;
      wlen_r    <= 8'd0;
      wbeat_r   <= 8'd0;
      wsize_r   <= 3'd0;
      wburst_r  <= 2'b00;
      werr_r    <= 1'b0;
    end else begin
      case (w_state_r)
        W_IDLE: if (aw_hs_s) begin
          wid_r     <= S_AXI_AWID;
          waddr_r   <= S_AXI_AWADDR;
          wlen_r    <= S_AXI_AWLEN;
          wsize_r   <= S_AXI_AWSIZE;
          wburst_r  <= S_AXI_AWBURST;
          wbeat_r   <= 8'd0;
          werr_r    <= 1'b0;
          awready_r <= 1'b0;
          wready_r  <= 1'b1;
        end
        W_DATA: if (w_hs_s) begin
          if (w_last_beat_s) begin
            wready_r <= 1'b0;
            bvalid_r <= 1'b1;
            bid_r    <= wid_r;
            bresp_r  <= (werr_r || w_beat_err_s) ? 2'b10 : 2'b00;
          end else begin
            wbeat_r <= wbeat_r + 8'd1;
            waddr_r <= next_addr(waddr_r, wlen_r, wburst_r);
            werr_r  <= werr_r || w_beat_err_s;
          end
        end
        W_RESP: if (S_AXI_BREADY) begin
          bvalid_r  <= 1'b0;
          awready_r <= 1'b1;
        end
        default: begin
          awready_r <= 1'b1;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read channel: the next beat is fetched on each handshake, giving one beat per cycle
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rresp_r   <= 2'b00;
      rdata_r   <= '0;
      rid_r     <= '0;
      raddr_r   <= '0;
      rlen_r    <= 8'd0;
      rbeat_r   <= 8'd0;
      rsize_r   <= 3'd0;
      rburst_r  <= 2'b00;
    end else begin
      case (r_state_r)
        R_IDLE: if (ar_hs_s) begin
          rid_r     <= S_AXI_ARID;
          raddr_r   <= S_AXI_ARADDR;
          rlen_r    <= S_AXI_ARLEN;
          rsize_r   <= S_AXI_ARSIZE;
          rburst_r  <= S_AXI_ARBURST;
          rbeat_r   <= 8'd0;
          arready_r <= 1'b0;
          rvalid_r  <= 1'b1;
          rlast_r   <= (S_AXI_ARLEN == 8'd0);
          rdata_r   <= ar_legal_s ? mem[S_AXI_ARADDR[ADDR_LSB +: IDX_W]] : '0;
          rresp_r   <= ar_legal_s ? 2'b00 : 2'b10;
        end
        R_DATA: if (r_hs_s) begin
          if (rlast_r) begin
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            arready_r <= 1'b1;
          end else begin
            raddr_r <= r_nxt_addr_s;
            rbeat_r <= rbeat_r + 8'd1;
            rlast_r <= ((rbeat_r + 8'd1) == rlen_r);
            rdata_r <= r_nxt_legal_s ? mem[r_nxt_addr_s[ADDR_LSB +: IDX_W]] : '0;
            rresp_r <= ((rresp_r != 2'b00) || !r_nxt_legal_s) ? 2'b10 : 2'b00;
          end
        end
        default: begin
          arready_r <= 1'b1;
          rvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_BID     = bid_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RLAST   = rlast_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RID     = rid_r;

endmodule

// File: tb/tb_aes_axi4_burst_buffer.sv
// Randomised self-checking bench for aes_axi4_burst_buffer against a word-array reference model.
module tb_aes_axi4_burst_buffer;

  logic        clk = 1'b0;
  logic        ARESET;
  logic [0:0]  AWID, BID, ARID, RID;
  logic [7:0]  AWADDR, AWLEN, ARADDR, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  always #5 clk = ~clk;

  aes_axi4_burst_buffer dut (
    .ACLK(clk), .ARESET(ARESET),
    .S_AXI_AWID(AWID), .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN), .S_AXI_AWSIZE(AWSIZE),
    .S_AXI_AWBURST(AWBURST), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST), .S_AXI_WVALID(WVALID),
    .S_AXI_WREADY(WREADY), .S_AXI_BID(BID), .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID),
    .S_AXI_BREADY(BREADY), .S_AXI_ARID(ARID), .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN),
    .S_AXI_ARSIZE(ARSIZE), .S_AXI_ARBURST(ARBURST), .S_AXI_ARVALID(ARVALID),
    .S_AXI_ARREADY(ARREADY), .S_AXI_RID(RID), .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP),
    .S_AXI_RLAST(RLAST), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte address of beat i, straight from the burst rules
  function automatic int beat_addr(input int a, input int len, input int burst, input int i);
    int wb, base;
    if (burst == 0) return a;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      wb   = (len + 1) * 4;
      base = (a / wb) * wb;
      return base + ((a - base) + i * 4) % wb;
    end
    return a + i * 4;
  endfunction

  function automatic bit model_legal(input int a, input int len, input int size, input int burst);
    if (size != 2 || burst == 3 || a >= 64) return 1'b0;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
    return 1'b1;
  endfunction

  // wl_mode: 0 correct WLAST, 1 early on beat 0, 2 never; abort_at > 0 resets after that many beats
  task automatic do_write(input int addr, input int len, input int size, input int burst,
                          input int bdelay, input int wl_mode, input int abort_at);
    int t, a;
    bit err, lg;
    logic last_b;
    logic [0:0] id;
    err = 1'b0;
    id  = 1'($urandom);
    AWID = id; AWADDR = 8'(addr); AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
    AWVALID = 1'b1;
    t = 0;
    while (AWREADY !== 1'b1 && t < 20) begin tick(); t++; end
    if (t >= 20) begin check_val("aw_timeout", 32'(t), 32'd0); AWVALID = 1'b0; return; end
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      last_b = (wl_mode == 0) ? (i == len) : (wl_mode == 1) ? (i == 0) : 1'b0;
      WDATA = wd[i]; WSTRB = ws[i]; WLAST = last_b; WVALID = 1'b1;
      t = 0;
      while (WREADY !== 1'b1 && t < 20) begin tick(); t++; end
      if (t >= 20) begin check_val("w_timeout", 32'(t), 32'd0); WVALID = 1'b0; return; end
      tick();
      a  = beat_addr(addr, len, burst, i);
      lg = model_legal(a, len, size, burst);
      if (lg) for (int b = 0; b < 4; b++) if (ws[i][b]) ref_mem[a / 4][8*b +: 8] = wd[i][8*b +: 8];
      if (!lg || (last_b != (i == len))) err = 1'b1;
      if (i + 1 == abort_at) begin
        WVALID = 1'b0; WLAST = 1'b0; ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        check_val("abort_reset", {27'd0, AWREADY, WREADY, BVALID, ARREADY, RVALID}, 32'b10010);
        tick();
        check_val("abort_quiet", {30'd0, BVALID, AWREADY}, 32'b01);
        return;
      end
    end
    WVALID = 1'b0; WLAST = 1'b0;
    check_val("bvalid_lat", 32'(BVALID), 32'd1);
    check_val("wready_off", 32'(WREADY), 32'd0);
    BREADY = 1'b0;
    for (int c = 0; c < bdelay; c++) begin
      tick();
      check_val("b_hold", {30'd0, BVALID, AWREADY}, 32'b10);
    end
    check_val("bresp", 32'(BRESP), err ? 32'd2 : 32'd0);
    check_val("bid", 32'(BID), 32'(id));
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check_val("b_done", {30'd0, BVALID, AWREADY}, 32'b01);
  endtask

  // rmode: 0 RREADY high, 1 pattern 1,0,0,1, 2 random
  task automatic do_read(input int addr, input int len, input int size, input int burst, input int rmode);
    logic [31:0] ed [16];
    logic [1:0]  er [16];
    bit sticky, lg;
    int a, k, cyc, t;
    logic [0:0] id;
    sticky = 1'b0;
    for (int i = 0; i <= len; i++) begin
      a  = beat_addr(addr, len, burst, i);
      lg = model_legal(a, len, size, burst);
      if (!lg) sticky = 1'b1;
      ed[i] = lg ? ref_mem[a / 4] : 32'd0;
      er[i] = sticky ? 2'b10 : 2'b00;
    end
    id = 1'($urandom);
    ARID = id; ARADDR = 8'(addr); ARLEN = 8'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
    ARVALID = 1'b1;
    t = 0;
    while (ARREADY !== 1'b1 && t < 20) begin tick(); t++; end
    if (t >= 20) begin check_val("ar_timeout", 32'(t), 32'd0); ARVALID = 1'b0; return; end
    tick();
    ARVALID = 1'b0;
    check_val("rvalid_lat", 32'(RVALID), 32'd1);
    k = 0; cyc = 0;
    while (k <= len && cyc < 200) begin
      RREADY = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3))
                                                  : 1'($urandom_range(0, 1));
      check_val("rvalid", 32'(RVALID), 32'd1);
      check_val("rdata", RDATA, ed[k]);
      check_val("rresp", 32'(RRESP), 32'(er[k]));
      check_val("rlast", 32'(RLAST), 32'(k == len));
      check_val("rid", 32'(RID), 32'(id));
      if (RREADY) k++;
      tick();
      cyc++;
    end
    RREADY = 1'b0;
    check_val("r_beats", 32'(k), 32'(len + 1));
    check_val("r_done", {30'd0, RVALID, ARREADY}, 32'b01);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'hF;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int addr, len, size, burst;
    ARESET = 1'b1;
    AWID = 1'b0; AWADDR = 8'd0; AWLEN = 8'd0; AWSIZE = 3'd0; AWBURST = 2'd0; AWVALID = 1'b0;
    WDATA = 32'd0; WSTRB = 4'd0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = 1'b0; ARADDR = 8'd0; ARLEN = 8'd0; ARSIZE = 3'd0; ARBURST = 2'd0; ARVALID = 1'b0;
    RREADY = 1'b0;
    tick(); tick();
    check_val("rst_ready", {27'd0, AWREADY, WREADY, BVALID, ARREADY, RVALID}, 32'b10010);
    check_val("rst_rdata", RDATA, 32'd0);
    check_val("rst_misc", {26'd0, RLAST, RRESP, BRESP, BID ^ RID}, 32'd0);
    check_val("rst_ids", {30'd0, BID, RID}, 32'd0);
    ARESET = 1'b0;
    tick();

    fill_random(16);
    do_write(0, 15, 2, 1, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(0, 7, 2, 1, 0, 0, 0);
    do_read(0, 7, 2, 1, 0);
    do_read(8, 3, 2, 2, 0);
    do_read(8, 2, 2, 2, 0);

    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    do_write(4, 3, 2, 0, 0, 0, 0);
    do_read(0, 15, 2, 1, 0);

    wd[0] = 32'h1; ws[0] = 4'hF;
    do_write(0, 0, 2, 1, 0, 0, 0);
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0101;
    do_write(0, 0, 2, 1, 0, 0, 0);
    do_read(0, 0, 2, 1, 0);
    check_val("strobe_word0", RDATA, 32'h00FF_00FF);

    fill_random(4);
    do_write(8'h38, 3, 2, 1, 0, 0, 0);
    do_write(8'h10, 3, 1, 1, 0, 0, 0);
    do_read(0, 15, 2, 1, 0);

    do_read(0, 7, 2, 1, 1);
    fill_random(2);
    do_write(8'h20, 1, 2, 1, 5, 0, 0);

    fill_random(4);
    do_write(0, 3, 2, 1, 0, 1, 0);
    do_write(8'h10, 3, 2, 1, 0, 2, 0);

    fill_random(8);
    do_write(0, 7, 2, 1, 0, 0, 3);
    fill_random(4);
    do_write(8'h20, 3, 2, 1, 0, 0, 0);
    do_read(0, 15, 2, 1, 0);

    for (int n = 0; n < 40; n++) begin
      size  = ($urandom_range(0, 9) == 0) ? 1 : 2;
      burst = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
      if (burst == 2) begin
        case ($urandom_range(0, 3))
          0:       len = 1;
          1:       len = 3;
          2:       len = 7;
          default: len = 2;
        endcase
      end else begin
        len = int'($urandom_range(0, 7));
      end
      addr = int'($urandom_range(0, 19)) * 4;
      if ($urandom_range(0, 1) == 1) begin
        fill_random(len + 1);
        for (int i = 0; i <= len; i++) ws[i] = 4'($urandom);
        do_write(addr, len, size, burst, int'($urandom_range(0, 2)),
                 ($urandom_range(0, 7) == 0) ? 2 : 0, 0);
      end else begin
        do_read(addr, len, size, burst, 2);
      end
    end
    do_read(0, 15, 2, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
